// File: rtl/mfp_input_cond.sv
// N-channel input conditioner: synchronizer, polarity fix, debounce, edge pulses,
// auto-repeat and sticky W1C event flags with a registered interrupt.

module mfp_input_cond_ch #(
    parameter int DB_CYCLES    = 250000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_a,
    input  logic i_rep_en,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_rpt
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HC_DELAY = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HC_RATE  = HW'(REPEAT_RATE);
    localparam logic [HW-1:0] HC_ONE   = HW'(1);

    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hc;
    logic          r_phase;
    logic          w_accept;
    logic          w_lvl_nxt;
    logic          w_rep_on;
    logic          w_rep_hit;

    assign w_accept  = (i_a != o_level) && (r_cnt == DB_LAST);
    assign w_lvl_nxt = w_accept ? i_a : o_level;
    // Repeat logic follows the level being registered this edge, so an
    // accepted fall suppresses any repeat terminal on the same edge.
    assign w_rep_on  = w_lvl_nxt & i_rep_en;
    assign w_rep_hit = w_rep_on && !w_accept &&
                       (r_hc == (r_phase ? HC_RATE : HC_DELAY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            if ((i_a == o_level) || w_accept) r_cnt <= '0;
            else                              r_cnt <= r_cnt + 1'b1;
            o_level <= w_lvl_nxt;
            o_rise  <= w_accept & i_a;
            o_fall  <= w_accept & ~i_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc    <= '0;
            r_phase <= 1'b0;
            o_rpt   <= 1'b0;
        end else begin
            o_rpt <= w_rep_hit;
            if (!w_rep_on) begin
                r_hc    <= '0;
                r_phase <= 1'b0;
            end else if (w_accept) begin
                r_hc    <= HC_ONE;
                r_phase <= 1'b0;
            end else if (w_rep_hit) begin
                r_hc    <= HC_ONE;
                r_phase <= 1'b1;
            end else begin
                r_hc    <= r_hc + 1'b1;
            end
        end
    end
endmodule

module mfp_input_cond #(
    parameter int              N_CH         = 16,
    parameter int              DB_CYCLES    = 250000,
    parameter int              REPEAT_DELAY = 25000000,
    parameter int              REPEAT_RATE  = 5000000,
    parameter logic [N_CH-1:0] INV_MASK     = '0
) (
    input  logic            SI_ClkIn,
    input  logic            SI_Reset_N,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] rep_en,
    input  logic [N_CH-1:0] irq_en,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] rpt,
    output logic [N_CH-1:0] evt,
    output logic            irq
);
    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;
    logic [N_CH-1:0] w_a;
    logic [N_CH-1:0] w_evt_nxt;

    // Synchronizer resets to the inactive pin level so nothing fires at release.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            r_s1 <= INV_MASK;
            r_s2 <= INV_MASK;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    assign w_a = r_s2 ^ INV_MASK;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mfp_input_cond_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk     (SI_ClkIn),
            .rst_n   (SI_Reset_N),
            .i_a     (w_a[g]),
            .i_rep_en(rep_en[g]),
            .o_level (level[g]),
            .o_rise  (rise[g]),
            .o_fall  (fall[g]),
            .o_rpt   (rpt[g])
        );
    end

    // Set beats clear when both land in the same cycle.
    assign w_evt_nxt = (evt & ~evt_clr) | rise | rpt;

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            evt <= '0;
            irq <= 1'b0;
        end else begin
            evt <= w_evt_nxt;
            irq <= |(w_evt_nxt & irq_en);
        end
    end
endmodule

// File: tb/tb_mfp_input_cond.sv
// Randomized + directed bench for mfp_input_cond against a behavioural model.

module tb_mfp_input_cond;
    localparam int        N   = 4;
    localparam int        DB  = 4;
    localparam int        RD  = 10;
    localparam int        RR  = 3;
    localparam logic [3:0] INV = 4'b1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw, rep_en, irq_en, evt_clr;
    logic [N-1:0] level, rise, fall, rpt, evt;
    logic         irq;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    mfp_input_cond #(
        .N_CH(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .INV_MASK(INV)
    ) dut (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n), .raw_in(raw), .rep_en(rep_en),
        .irq_en(irq_en), .evt_clr(evt_clr), .level(level), .rise(rise),
        .fall(fall), .rpt(rpt), .evt(evt), .irq(irq)
    );

    // Model: run length of disagreement with the level, and age since rise.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_rpt, m_evt;
    logic         m_irq;
    int           m_run[N];
    int           m_age[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_s1 = INV; m_s2 = INV; m_lvl = '0; m_rise = '0; m_fall = '0;
        m_rpt = '0; m_evt = '0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_age[i] = -1;
        end
    endtask

    task automatic m_edge();
        logic [N-1:0] a, nl, nr, nf, np, ne;
        a = m_s2 ^ INV; nl = m_lvl; nr = '0; nf = '0; np = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i] == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_run[i] = 0; nl[i] = a[i]; nr[i] = a[i]; nf[i] = ~a[i];
                end
            end
            if (nr[i]) m_age[i] = 0;
            else if (!nl[i] || !rep_en[i] || m_age[i] < 0) m_age[i] = -1;
            else begin
                m_age[i]++;
                np[i] = (m_age[i] >= RD) && (((m_age[i] - RD) % RR) == 0);
            end
        end
        ne = (m_evt & ~evt_clr) | m_rise | m_rpt;
        m_irq = |(ne & irq_en);
        m_evt = ne; m_lvl = nl; m_rise = nr; m_fall = nf; m_rpt = np;
        m_s2 = m_s1; m_s1 = raw;
    endtask

    task automatic cmp_all();
        chk("level", level, m_lvl);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("rpt", rpt, m_rpt);
        chk("evt", evt, m_evt);
        chk("irq", irq, m_irq);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) m_edge(); else m_reset();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic drain();
        raw = INV; evt_clr = '0;
        repeat (12) step();
    endtask

    int k, cnt, first, r;
    logic seq[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        raw = INV; rep_en = '0; irq_en = '0; evt_clr = '0;
        m_reset();
        #1;
        chk("rst_level", level, 0);
        chk("rst_evt", evt, 0);
        chk("rst_irq", irq, 0);
        repeat (3) step();
        @(negedge clk); rst_n = 1'b1;
        repeat (20) step();
        chk("idle_level", level, 0);

        // Clean press/release on channel 0
        irq_en = 4'b0001;
        raw[0] = 1'b1; k = 0;
        for (int c = 1; c <= 10; c++) begin step(); if (rise[0] && k == 0) k = c; end
        chk("press_lat", k, 6);
        chk("press_evt", evt[0], 1);
        chk("press_irq", irq, 1);
        raw[0] = 1'b0; k = 0;
        for (int c = 1; c <= 10; c++) begin step(); if (fall[0] && k == 0) k = c; end
        chk("release_lat", k, 6);
        chk("fall_evt_kept", evt[0], 1);
        evt_clr = 4'b0001; step(); evt_clr = '0;
        chk("clr_evt", evt[0], 0);
        chk("clr_irq", irq, 0);

        // Bounce on channel 1
        cnt = 0;
        for (int c = 0; c < 8; c++) begin raw[1] = seq[c]; step(); cnt += int'(rise[1]); end
        repeat (8) begin step(); cnt += int'(rise[1]); end
        chk("bounce_rises", cnt, 1);
        chk("ch1_no_irq", irq, 0);
        raw[1] = 1'b0; repeat (10) step();

        // 3-cycle glitch on channel 2
        cnt = 0; raw[2] = 1'b1;
        repeat (3) begin step(); cnt += int'(level[2]); end
        raw[2] = 1'b0;
        repeat (10) begin step(); cnt += int'(level[2]); end
        chk("glitch_level", cnt, 0);

        // Active-low channel 3
        raw[3] = 1'b0; k = 0;
        for (int c = 1; c <= 10; c++) begin step(); if (rise[3] && k == 0) k = c; end
        chk("pol_lat", k, 6);
        raw[3] = 1'b1; repeat (10) step();

        // Clear coincident with rise keeps the flag
        evt_clr = 4'b0001; step(); evt_clr = '0;
        raw[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin step(); evt_clr = {3'b000, rise[0]}; end
        evt_clr = '0;
        chk("set_wins", evt[0], 1);
        drain();

        // Auto-repeat on channel 2
        rep_en = 4'b0100; raw[2] = 1'b1; r = 0; first = 0; cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (rise[2]) r = c;
            if (rpt[2]) begin cnt++; if (first == 0) first = c; end
        end
        chk("rpt_first", first - r, 10);
        chk("rpt_cnt", cnt, 9);
        raw[2] = 1'b0; cnt = 0;
        for (int c = 1; c <= 15; c++) begin step(); if (c > 6) cnt += int'(rpt[2]); end
        chk("rpt_after_rel", cnt, 0);
        drain();
        rep_en = '0; raw[2] = 1'b1; cnt = 0;
        repeat (30) begin step(); cnt += int'(rpt[2]); end
        chk("rpt_disabled", cnt, 0);
        drain();

        // Reset mid-repeat
        rep_en = 4'b0100; raw[2] = 1'b1;
        repeat (20) step();
        rst_n = 1'b0; #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_rpt", rpt, 0);
        chk("mid_rst_evt", evt, 0);
        chk("mid_rst_irq", irq, 0);
        m_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        drain();

        // Randomized phases
        for (int p = 0; p < 4; p++) begin
            rep_en = N'($urandom); irq_en = N'($urandom);
            repeat (200) begin
                for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
                evt_clr = N'($urandom) & N'($urandom);
                step();
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mfp_input_cond.md
# mfp_input_cond

Parametrised input conditioner for the Nexys4 DDR top level. It replaces the fixed pushbutton/switch debouncers used for onboard buttons, slide switches and PMOD JA inputs with one N-channel block. Each channel has:
- a two-flop synchronizer
- per-channel polarity inversion
- a debounce filter
- rise/fall pulses
- optional auto-repeat
- sticky write-one-to-clear event flags with an interrupt output, for the MIPSfpga GPIO/AHB peripheral

## Interface
- N_CH, 16: number of input channels (1..32)
- DB_CYCLES, 250000: consecutive stable cycles required to accept a new level (5 ms at 50 MHz); ≥2
- REPEAT_DELAY, 25000000: hold cycles from accepted rise to first repeat pulse (500 ms); ≥1
- REPEAT_RATE, 5000000: cycles between subsequent repeat pulses (100 ms); 1..REPEAT_DELAY
- INV_MASK, 0: bit i=1 means channel i is active-low at the pin (e.g. CPU_RESETN)

Ports:
- SI_ClkIn  in  1  system clock (50 MHz domain)
- SI_Reset_N  in  1  asynchronous active-low reset
- raw_in  in  N_CH  unsynchronised pin levels
- rep_en  in  N_CH  per-channel auto-repeat enable
- irq_en  in  N_CH  per-channel interrupt enable
- evt_clr  in  N_CH  write-one-to-clear strobe for evt, one cycle
- level  out  N_CH  debounced, polarity-corrected level (1 = active)
- rise  out  N_CH  one-cycle pulse when level goes 0→1
- fall  out  N_CH  one-cycle pulse when level goes 1→0
- rpt  out  N_CH  one-cycle auto-repeat pulse
- evt  out  N_CH  sticky event flags
- irq  out  1  OR of (evt & irq_en)

## Operation
- **Synchronizer:** s1 ← raw_in, s2 ← s1. After reset, s1/s2 hold INV_MASK (inactive pin level). Then a = s2 ^ INV_MASK.
- **Debounce, per channel:** counter cnt of width clog2(DB_CYCLES).
  - If a == level: cnt ← 0.
  - Else if cnt == DB_CYCLES−1: level ← a, cnt ← 0, and a rise or fall pulse is registered on that same edge.
  - Else: cnt ← cnt+1.
  - Any bounce back to the current level clears cnt. A pulse shorter than DB_CYCLES cycles never reaches level.
- **Auto-repeat, per channel:** hold counter hc of width clog2(REPEAT_DELAY+1), plus a flag phase (0 = initial delay, 1 = repeating).
  - On accepted rise: hc ← 1, phase ← 0.
  - While level=1 and rep_en[i]=1: hc increments.
  - phase 0: when hc == REPEAT_DELAY, rpt pulses, hc ← 1, phase ← 1.
  - phase 1: when hc == REPEAT_RATE, rpt pulses, hc ← 1.
  - level=0 or rep_en[i]=0: hc ← 0, phase ← 0, no rpt.
- **Events:**
  - evt[i] sets on rise[i] or rpt[i]. Fall does not set evt.
  - evt_clr[i] clears evt[i].
  - Set and clear in the same cycle: set wins.
- **irq** is registered: irq ← |(next_evt & irq_en).
- **Reset** (asserting at any time, including mid-count or mid-repeat) asynchronously clears all of the following, and the block resumes filtering from the inactive state:
  - cnt, hc, phase
  - level, rise, fall, rpt
  - evt, irq
- If an input is physically active at reset release, it is accepted after the normal debounce latency and produces a rise.

## Timing
- All outputs are registered. Reset values:
  - level=0, rise=0, fall=0, rpt=0, evt=0, irq=0
  - s1/s2 = INV_MASK
- **Debounce latency:** a raw change sampled into s1 at edge E, held stable, updates level and pulses rise/fall at edge E+1+DB_CYCLES.
- rise/fall/rpt are high for exactly one cycle. They coincide with the level change or counter terminal.
- **evt timing:**
  - evt rises one edge after rise/rpt.
  - irq rises on the same edge as evt.
  - Clear takes effect on the edge after evt_clr is sampled.
- **First repeat:** REPEAT_DELAY cycles after the rise pulse. Subsequent repeats: every REPEAT_RATE cycles.
- Channels are fully independent. Simultaneous events on multiple channels are all reported in the same cycle.

## Test plan
Parameters for the bench: N_CH=4, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, INV_MASK=4'b1000.
- **Reset:** hold SI_Reset_N=0 with raw_in=4'b1000 → level/rise/fall/rpt/evt/irq all 0. After release, level stays 0 indefinitely.
- **Clean press:** raw_in[0] 0→1 sampled at edge E → level[0]=1 and rise[0] one cycle at edge E+5, evt[0]=1 at E+6. Release → fall[0] at release-edge+5, evt unchanged.
- **Bounce:** raw_in[1] toggles 1,1,1,0,1,1,1,1 cycle by cycle → single rise[1] only after the final 4-cycle stable run. A 3-cycle glitch alone → no level change.
- **Polarity:** raw_in[3] 1→0 → level[3]=1 and rise[3] after 5 edges.
- **Auto-repeat:** rep_en[2]=1, hold channel 2 → rpt[2] pulses 10 cycles after rise[2], then every 3 cycles. Release → no further rpt. With rep_en[2]=0 → no rpt.
- **Events/irq:** irq_en=4'b0001.
  - evt[0] set gives irq=1; evt_clr=4'b0001 clears both next edge.
  - evt_clr coincident with rise[0] → evt[0] stays 1.
  - evt[1] set alone → irq stays 0.
  - Reset asserted mid-repeat → all outputs 0 immediately.
